// File: rtl/ppl_stage.sv
// ppl_stage: two-entry skid-buffered pipeline register with valid/ready handshake, hold and flush.
// Ports: clk, rst (sync, active-high), flush, hold,
//        up_valid/up_ready/up_data (upstream), dn_valid/dn_ready/dn_data (downstream),
//        level (stored entries), stall_cnt/drop_cnt (statistics, live only with PPL_STAGE_STATS_EN).
module ppl_stage #(
  parameter int DATA_W = 48,
  parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        level,
  output logic [15:0]       stall_cnt,
  output logic [7:0]        drop_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic accept, emit;
  // The state encoding doubles as the entry count.
  assign level    = rst ? 2'd0 : 2'(state_q);
  assign up_ready = ~rst & (state_q != FULL) & ~hold & ~flush;
  assign dn_valid = ~rst & (state_q != EMPTY) & ~hold & ~flush;
  assign dn_data  = main_q;
  assign accept   = up_valid & up_ready;
  assign emit     = dn_valid & dn_ready;
  // hold and flush already gate accept/emit, so a held stage simply falls through unchanged.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = CLEAR_VAL;
      skid_d  = CLEAR_VAL;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          main_d  = up_data;
        end
        ONE: if (accept & emit) main_d = up_data;
          else if (accept) begin
            state_d = FULL;
            skid_d  = up_data;
          end else if (emit) state_d = EMPTY;
        FULL: if (emit) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= CLEAR_VAL;
      skid_q  <= CLEAR_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
`ifdef PPL_STAGE_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [7:0]  drop_q, drop_d;
  assign stall_d = (dn_valid & ~dn_ready & ~&stall_q) ? stall_q + 16'd1 : stall_q;
  assign drop_d  = (flush & (state_q != EMPTY) & ~&drop_q) ? drop_q + 8'd1 : drop_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end
  assign stall_cnt = stall_q;
  assign drop_cnt  = drop_q;
`else
  assign stall_cnt = '0;
  assign drop_cnt  = '0;
`endif
endmodule

// File: doc/ppl_stage.md
PPL_STAGE -- requirements
Module: ppl_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 48, payload width in bits (16-bit address + 32-bit instruction).
REQ-002 SHALL have parameter CLEAR_VAL, default {DATA_W{1'b0}}, the value loaded into the data registers on reset and flush.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  discard all stored entries (pipeline clear).
REQ-006 SHALL have port hold  input  1  freeze the stage (pipeline stall).
REQ-007 SHALL have port up_valid  input  1  upstream payload valid.
REQ-008 SHALL have port up_ready  output  1  stage can accept the upstream payload.
REQ-009 SHALL have port up_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port dn_valid  output  1  downstream payload valid.
REQ-011 SHALL have port dn_ready  input  1  downstream consumer accepts the payload.
REQ-012 SHALL have port dn_data  output  DATA_W  downstream payload (main register).
REQ-013 SHALL have port level  output  2  number of stored entries (0, 1 or 2).
REQ-014 SHALL have port stall_cnt  output  16  downstream back-pressure cycle counter (see Configuration).
REQ-015 SHALL have port drop_cnt  output  8  count of flushes that discarded valid entries (see Configuration).

Function
REQ-016 SHALL hold entries in two registers, main and skid, forming a three-state FSM: EMPTY (level 0), ONE (main valid) and FULL (main and skid valid).
REQ-017 SHALL define accept = up_valid & up_ready and emit = dn_valid & dn_ready.
REQ-018 SHALL drive up_ready = (state != FULL) & ~hold & ~flush.
REQ-019 SHALL drive dn_valid = (state != EMPTY) & ~hold & ~flush.
REQ-020 SHALL make dn_data always equal main, and not gate dn_data with dn_valid.
REQ-021 EMPTY transitions: on accept, SHALL go to ONE with main <= up_data; otherwise SHALL stay EMPTY.
REQ-022 ONE transitions: on accept & emit, SHALL stay ONE with main <= up_data.
REQ-023 ONE transitions: on accept & ~emit, SHALL go to FULL with skid <= up_data.
REQ-024 ONE transitions: on emit & ~accept, SHALL go to EMPTY; with neither event, SHALL stay ONE.
REQ-025 FULL transitions: on emit, SHALL go to ONE with main <= skid; otherwise SHALL stay FULL. Accept is impossible in FULL.
REQ-026 SHALL give a minimum latency of 1 cycle: data accepted in cycle N is presented on dn_data in cycle N+1.
REQ-027 SHALL preserve FIFO order, and SHALL neither drop nor duplicate payloads except on flush.
REQ-028 SHALL sustain full throughput: with up_valid=1 and dn_ready=1 held continuously and no hold, SHALL pass one payload per cycle.
REQ-029 On hold=1, SHALL retain state, main and skid unchanged, with no accept or emit.
REQ-030 On flush=1, SHALL go to EMPTY next cycle and load main and skid with CLEAR_VAL.
REQ-031 flush SHALL override hold, accept and emit; no accept or emit occurs in the flush cycle.
REQ-032 SHALL drive level combinationally from the FSM state.

Reset
REQ-033 On rst=1 at a clock edge, SHALL set state to EMPTY, main and skid to CLEAR_VAL, and stall_cnt and drop_cnt to 0.
REQ-034 While rst=1, SHALL drive up_ready=0, dn_valid=0 and level=0.
REQ-035 rst SHALL take priority over flush, hold and all transfers.
REQ-036 Reset asserted mid-transfer SHALL discard all contents; no partial update is permitted.

Configuration
REQ-037 The macro `PPL_STAGE_STATS_EN SHALL, when defined, enable both statistics counters described in REQ-038 and REQ-039.
REQ-038 stall_cnt SHALL increment by one each cycle with dn_valid & ~dn_ready, saturating at 16'hFFFF.
REQ-039 drop_cnt SHALL increment by one on each flush cycle with state != EMPTY, saturating at 8'hFF.
REQ-040 When `PPL_STAGE_STATS_EN is undefined, SHALL keep the stall_cnt and drop_cnt ports present, tie them to constant 0, and synthesise no counter logic.

Verification
REQ-041 SHALL cover reset: rst=1 for 2 cycles, then rst=0 -> level=0, dn_valid=0, up_ready=1, dn_data=CLEAR_VAL.
REQ-042 SHALL cover streaming: up_data=0x0000_1234_0004, 0x0000_5678_0008 on consecutive cycles with dn_ready=1 -> the same two values appear on dn_data in cycles N+1 and N+2, each with dn_valid=1.
REQ-043 SHALL cover skid fill: dn_ready=0 while A and then B are accepted -> level=2 and up_ready=0; then dn_ready=1 -> A, then B on consecutive cycles; level reaches 0.
REQ-044 SHALL cover hold: with level=1, hold=1 for 3 cycles while up_valid=1 -> dn_valid=0, up_ready=0 and level=1 throughout; after release, the original payload is emitted first.
REQ-045 SHALL cover flush priority: with level=2, flush=1 and hold=1 together -> next cycle level=0 and dn_data=CLEAR_VAL; with the macro defined, drop_cnt increments by 1; a flush applied when already empty leaves drop_cnt unchanged.
REQ-046 SHALL cover counter saturation: with the macro defined, dn_valid=1 and dn_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; with the macro undefined, stall_cnt=0.
